// File: rtl/irq_collector_16.sv
// -----------------------------------------------------------------------------
// irq_collector_16
//
// Interrupt aggregator for 16 peripheral IRQ lines (bit i = source i).
// Each line is synchronised, then latched as a pending request:
//   - edge mode: set on a rising edge, held until claimed;
//   - level mode: follows the line every cycle.
// Pending requests are masked and gated by in-service state. The lowest
// index wins (source 0 has the highest priority). The CPU takes the winner
// with a claim/complete handshake.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   irq_in[15:0]  raw asynchronous IRQ lines
//   irq_en[15:0]  per-source enable mask
//   irq_edge[15:0] per-source mode: 1 = rising edge, 0 = level high
//   irq_out       registered CPU interrupt request
//   claim_req     1-cycle claim strobe
//   claim_ack     1-cycle response, one cycle after claim_req
//   claim_valid   claim_id holds a granted source (qualified by claim_ack)
//   claim_id[3:0] granted source index (0 when nothing was granted)
//   complete_req  1-cycle completion strobe
//   complete_id   source being completed
//   stat_sel      event counter select
//   stat_cnt      selected event count (always 0 unless IRQ_STAT_EN)
//
// Configuration
//   IRQ_STAT_EN   build saturating per-source event counters
//
// SYNC_STAGES is legal from 2 to 3.
// -----------------------------------------------------------------------------
module irq_collector_16 #(
  parameter int SYNC_STAGES = 2,
  parameter int STAT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       irq_in,
  input  logic [15:0]       irq_en,
  input  logic [15:0]       irq_edge,
  output logic              irq_out,
  input  logic              claim_req,
  output logic              claim_ack,
  output logic              claim_valid,
  output logic [3:0]        claim_id,
  input  logic              complete_req,
  input  logic [3:0]        complete_id,
  input  logic [3:0]        stat_sel,
  output logic [STAT_W-1:0] stat_cnt
);

  localparam int N = 16;

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] s;
  logic [N-1:0] s_d;
  logic [N-1:0] rise;
  logic [N-1:0] pending;
  logic [N-1:0] in_service;
  logic [N-1:0] in_service_nxt;
  logic [N-1:0] cand;
  logic [N-1:0] grant_mask;
  logic [3:0]   winner;
  logic         any_cand;

  // ---------------------------------------------------------------------------
  // Synchroniser chain and one-cycle delayed copy for edge detection
  // ---------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments, so every stage samples the
  // previous stage's old value; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // ---------------------------------------------------------------------------
  // Candidate selection: fixed priority, lowest index wins
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    cand       = pending & irq_en & ~in_service;
    any_cand   = |cand;
    winner     = '0;
    grant_mask = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) winner = 4'(i);
    end
    if (claim_req && any_cand) grant_mask[winner] = 1'b1;
  end

  // Complete clears first, grant sets after. A granted source is never the
  // one being completed, since in-service sources are excluded from cand.
  always_comb begin
    in_service_nxt = in_service;
    if (complete_req) in_service_nxt[complete_id] = 1'b0;
    in_service_nxt = in_service_nxt | grant_mask;
  end

  // ---------------------------------------------------------------------------
  // Pending, in-service and handshake registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      in_service  <= '0;
      irq_out     <= 1'b0;
      claim_ack   <= 1'b0;
      claim_valid <= 1'b0;
      claim_id    <= '0;
    end else begin
      // Edge sources: a new edge wins over a claim clearing the same bit.
      // Level sources simply track the synchronised line.
      pending     <= (irq_edge & (rise | (pending & ~grant_mask)))
                   | (~irq_edge & s);
      in_service  <= in_service_nxt;
      irq_out     <= any_cand;
      claim_ack   <= claim_req;
      claim_valid <= claim_req && any_cand;
      claim_id    <= (claim_req && any_cand) ? winner : 4'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional event counters
  // ---------------------------------------------------------------------------
`ifdef IRQ_STAT_EN
  logic [STAT_W-1:0] cnt [N];

  // NOTE: the counter array is explicitly reset; it is architecturally visible
  // through stat_cnt, so it cannot start from an unknown value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      // A synchronised rising edge is what sets an edge-mode pending bit,
      // and it is also the event counted for level-mode sources.
      for (int i = 0; i < N; i++) begin
        if (rise[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + STAT_W'(1);
      end
    end
  end

  assign stat_cnt = cnt[stat_sel];
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_irq_collector_16.sv
// -----------------------------------------------------------------------------
// tb_irq_collector_16
//
// Self-checking bench for irq_collector_16. It has three parts:
//   - A table of arbitration vectors. Each vector holds level lines and an
//     enable mask, plus the hand-computed grant.
//   - Hand-written handshake sequences for the multi-cycle corner cases.
//   - A randomized phase. It compares the DUT every cycle against a
//     reference model. The model keeps the raw input history, and derives the
//     synchronised view from that history by indexing back SYNC cycles.
// -----------------------------------------------------------------------------
module tb_irq_collector_16;

  localparam int SYNC    = 2;
  localparam int STAT_W  = 8;
  localparam int STATMAX = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       irq_in;
  logic [15:0]       irq_en;
  logic [15:0]       irq_edge;
  logic              irq_out;
  logic              claim_req;
  logic              claim_ack;
  logic              claim_valid;
  logic [3:0]        claim_id;
  logic              complete_req;
  logic [3:0]        complete_id;
  logic [3:0]        stat_sel;
  logic [STAT_W-1:0] stat_cnt;

  always #5 clk = ~clk;

  irq_collector_16 #(.SYNC_STAGES(SYNC), .STAT_W(STAT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .irq_en       (irq_en),
    .irq_edge     (irq_edge),
    .irq_out      (irq_out),
    .claim_req    (claim_req),
    .claim_ack    (claim_ack),
    .claim_valid  (claim_valid),
    .claim_id     (claim_id),
    .complete_req (complete_req),
    .complete_id  (complete_id),
    .stat_sel     (stat_sel),
    .stat_cnt     (stat_cnt)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit [15:0] hist[$];     // irq_in as sampled at each clock edge since reset
  bit [15:0] m_pend;
  bit [15:0] m_insvc;
  bit        m_irq;
  bit        m_ack;
  bit        m_valid;
  bit [3:0]  m_id;
  int        m_cnt [16];

  function automatic bit [15:0] hist_at(input int idx);
    return (idx < 0) ? 16'h0 : hist[idx];
  endfunction

  // Advance the model across one clock edge, using the inputs currently driven.
  task automatic model_step();
    int        n;
    int        first;
    bit [15:0] s_now;
    bit [15:0] s_old;
    bit        r;
    if (rst) begin
      hist.delete();
      m_pend  = '0;
      m_insvc = '0;
      m_irq   = 1'b0;
      m_ack   = 1'b0;
      m_valid = 1'b0;
      m_id    = '0;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      return;
    end
    n     = hist.size();
    s_now = hist_at(n - SYNC);
    s_old = hist_at(n - SYNC - 1);
    first = -1;
    for (int i = 0; i < 16; i++)
      if (first < 0 && m_pend[i] && irq_en[i] && !m_insvc[i]) first = i;
    m_irq   = (first >= 0);
    m_ack   = claim_req;
    m_valid = claim_req && (first >= 0);
    m_id    = m_valid ? 4'(first) : 4'd0;
    for (int i = 0; i < 16; i++) begin
      r = s_now[i] && !s_old[i];
      if (r && m_cnt[i] < STATMAX) m_cnt[i]++;
      if (irq_edge[i]) m_pend[i] = r || (m_pend[i] && !(m_valid && first == i));
      else             m_pend[i] = s_now[i];
    end
    if (complete_req) m_insvc[complete_id] = 1'b0;
    if (m_valid) m_insvc[first] = 1'b1;
    hist.push_back(irq_in);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    irq_in       = '0;
    claim_req    = 1'b0;
    complete_req = 1'b0;
    complete_id  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic claim_once();
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Arbitration vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] lines;
    logic [15:0] en;
    logic        exp_irq;
    logic        exp_valid;
    logic [3:0]  exp_id;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int start;
    int pick;

    vecs[0] = '{16'h0084, 16'hFFFF, 1'b1, 1'b1, 4'd2};
    vecs[1] = '{16'h8000, 16'hFFFF, 1'b1, 1'b1, 4'd15};
    vecs[2] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0};
    vecs[3] = '{16'hFFFF, 16'hFFFE, 1'b1, 1'b1, 4'd1};
    vecs[4] = '{16'h0A00, 16'h0800, 1'b1, 1'b1, 4'd11};
    vecs[5] = '{16'h1234, 16'h1230, 1'b1, 1'b1, 4'd4};
    vecs[6] = '{16'h00F0, 16'h000F, 1'b0, 1'b0, 4'd0};
    vecs[7] = '{16'h0001, 16'h0001, 1'b1, 1'b1, 4'd0};

    irq_en   = '0;
    irq_edge = '0;
    stat_sel = '0;
    do_reset();

    // Reset state
    check("reset_irq_out", irq_out, 0);
    check("reset_claim_ack", claim_ack, 0);
    check("reset_claim_valid", claim_valid, 0);
    check("reset_claim_id", claim_id, 0);
    check("reset_stat_cnt", stat_cnt, 0);

    // Table: level sources, then a single claim
    foreach (vecs[v]) begin
      do_reset();
      irq_edge = '0;
      irq_en   = vecs[v].en;
      irq_in   = vecs[v].lines;
      repeat (SYNC + 3) tick();
      check($sformatf("vec%0d_irq_out", v), irq_out, vecs[v].exp_irq);
      claim_once();
      check($sformatf("vec%0d_ack", v), claim_ack, 1);
      check($sformatf("vec%0d_valid", v), claim_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_id", v), claim_id, vecs[v].exp_id);
    end

    // Latency: edge on source 3 reaches irq_out after SYNC+2 edges
    do_reset();
    irq_en = 16'h0008; irq_edge = 16'h0008;
    irq_in[3] = 1'b1;
    repeat (SYNC + 1) tick();
    check("lat_before", irq_out, 0);
    tick();
    check("lat_at", irq_out, 1);

    // Back-to-back claims: sources 2 and 7 as edges
    do_reset();
    irq_en = 16'hFFFF; irq_edge = 16'hFFFF;
    irq_in = 16'h0084;
    repeat (SYNC + 3) tick();
    claim_req = 1'b1;
    tick();
    check("b2b_1_ack", claim_ack, 1);
    check("b2b_1_valid", claim_valid, 1);
    check("b2b_1_id", claim_id, 2);
    tick();
    check("b2b_2_valid", claim_valid, 1);
    check("b2b_2_id", claim_id, 7);
    tick();
    check("b2b_3_ack", claim_ack, 1);
    check("b2b_3_valid", claim_valid, 0);
    check("b2b_3_id", claim_id, 0);
    claim_req = 1'b0;
    tick();
    check("b2b_idle_ack", claim_ack, 0);

    // Level source held high while in service
    do_reset();
    irq_en = 16'hFFFF; irq_edge = 16'h0000;
    irq_in = 16'h0020;
    repeat (SYNC + 3) tick();
    claim_once();
    check("lvl_claim_id", claim_id, 5);
    check("lvl_claim_valid", claim_valid, 1);
    claim_once();
    check("lvl_reclaim_valid", claim_valid, 0);
    check("lvl_masked_irq", irq_out, 0);
    complete_req = 1'b1; complete_id = 4'd5;
    tick();
    complete_req = 1'b0;
    tick();
    check("lvl_reassert", irq_out, 1);

    // Disabled source keeps its pending bit
    do_reset();
    irq_en = 16'h0000; irq_edge = 16'h0200;
    irq_in[9] = 1'b1;
    repeat (6) tick();
    check("mask_irq_out", irq_out, 0);
    irq_en = 16'h0200;
    tick();
    tick();
    check("unmask_irq_out", irq_out, 1);
    claim_once();
    check("unmask_claim_id", claim_id, 9);

    // New edge on source 1 in its own claim cycle: pending survives
    do_reset();
    irq_en = 16'hFFFF; irq_edge = 16'h0002;
    irq_in[1] = 1'b1;
    repeat (SYNC + 3) tick();
    irq_in[1] = 1'b0;
    repeat (SYNC + 2) tick();
    irq_in[1] = 1'b1;
    repeat (SYNC) tick();
    claim_once();               // rising edge is detected on this same edge
    check("race_claim_valid", claim_valid, 1);
    check("race_claim_id", claim_id, 1);
    complete_req = 1'b1; complete_id = 4'd1;
    tick();
    complete_req = 1'b0;
    claim_once();
    check("race_reclaim_valid", claim_valid, 1);
    check("race_reclaim_id", claim_id, 1);

    // Completing an id that is not in service changes nothing
    complete_req = 1'b1; complete_id = 4'd12;
    tick();
    complete_req = 1'b0;
    claim_once();
    check("bogus_complete_valid", claim_valid, 0);

    // Reset during a claim: no ack follows
    do_reset();
    irq_en = 16'hFFFF; irq_edge = 16'h0010;
    irq_in[4] = 1'b1;
    repeat (SYNC + 3) tick();
    check("rst_hs_pre_irq", irq_out, 1);
    claim_req = 1'b1; rst = 1'b1;
    tick();
    check("rst_hs_ack", claim_ack, 0);
    check("rst_hs_valid", claim_valid, 0);
    check("rst_hs_irq", irq_out, 0);
    rst = 1'b0; claim_req = 1'b0;
    tick();
    check("rst_hs_ack_after", claim_ack, 0);

`ifdef IRQ_STAT_EN
    // Counter saturation on source 0
    do_reset();
    irq_en = 16'h0001; irq_edge = 16'h0001;
    for (int k = 0; k < 300; k++) begin
      irq_in[0] = 1'b1; tick();
      irq_in[0] = 1'b0; tick();
    end
    repeat (SYNC + 2) tick();
    stat_sel = 4'd0;
    #1;
    check("stat_sat", stat_cnt, STATMAX);
    stat_sel = 4'd1;
    #1;
    check("stat_other", stat_cnt, 0);
`else
    check("stat_tied_zero", stat_cnt, 0);
`endif

    // Randomized phase against the reference model
    do_reset();
    irq_edge = 16'($urandom);
    irq_en   = 16'($urandom | $urandom);
    for (int cyc = 0; cyc < 800; cyc++) begin
      irq_in    = irq_in ^ 16'($urandom & $urandom & $urandom);
      claim_req = ($urandom_range(0, 2) == 0);
      complete_req = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        start = $urandom_range(0, 15);
        pick  = -1;
        for (int k = 0; k < 16; k++)
          if (pick < 0 && m_insvc[(start + k) % 16]) pick = (start + k) % 16;
        complete_req = 1'b1;
        complete_id  = (pick < 0) ? 4'($urandom_range(0, 15)) : 4'(pick);
      end
      if (cyc % 100 == 99) irq_en = 16'($urandom | $urandom);
      if (cyc == 400) irq_edge = 16'($urandom);
      stat_sel = 4'($urandom_range(0, 15));
      tick();
      check($sformatf("rnd%0d_irq_out", cyc), irq_out, m_irq);
      check($sformatf("rnd%0d_ack", cyc), claim_ack, m_ack);
      check($sformatf("rnd%0d_valid", cyc), claim_valid, m_valid);
      check($sformatf("rnd%0d_id", cyc), claim_id, m_id);
`ifdef IRQ_STAT_EN
      check($sformatf("rnd%0d_stat", cyc), stat_cnt, m_cnt[stat_sel]);
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
